// File: rtl/prbs_pkg.sv
// Shared constants and types for the PRBS burst scheduler: mode encodings,
// polynomial taps, the non-zero fallback seeds and the FSM state type.
package prbs_pkg;

  localparam logic [1:0] MODE_PRBS7 = 2'b00;
  localparam logic [1:0] MODE_PRBS9 = 2'b01;

  // x^7 + x^6 + 1 and x^9 + x^5 + 1, as bit positions in the state register
  localparam int PRBS7_TAP_HI = 6;
  localparam int PRBS7_TAP_LO = 5;
  localparam int PRBS9_TAP_HI = 8;
  localparam int PRBS9_TAP_LO = 4;

  localparam logic [6:0] SEED7_ONES = 7'h7F;
  localparam logic [8:0] SEED9_ONES = 9'h1FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/prbs_burst_sched_lfsr.sv
// Shared PRBS7/PRBS9 generator. PRBS7 lives in bits [6:0] with [8:7] held at 0;
// an all-zero seed would lock the register, so it is replaced by all-ones.
module prbs_lfsr9
  import prbs_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [8:0] seed,
  input  logic [1:0] mode,
  input  logic       step,
  output logic [8:0] state
);

  logic [8:0] state_q, state_d;
  logic [8:0] seed_m;
  logic       is9;

  always_comb begin
    is9    = (mode == MODE_PRBS9);
    seed_m = is9 ? seed : {2'b00, seed[6:0]};
    if (seed_m == '0) seed_m = is9 ? SEED9_ONES : {2'b00, SEED7_ONES};
    state_d = state_q;
    if (load) begin
      state_d = seed_m;
    end else if (step) begin
      if (is9) state_d = {state_q[7:0], state_q[PRBS9_TAP_HI] ^ state_q[PRBS9_TAP_LO]};
      else     state_d = {2'b00, state_q[5:0], state_q[PRBS7_TAP_HI] ^ state_q[PRBS7_TAP_LO]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/prbs_burst_sched.sv
// Round-robin scheduler sharing one PRBS generator between requesters.
// state | meaning
// IDLE  | waiting for any req; arbitrates from rr_ptr upward
// LOAD  | seed loaded into LFSR, count loaded with burst length
// RUN   | streaming words on the valid/ready port
// DONE  | one-cycle done/aborted pulse, rr_ptr advances past the owner
module prbs_burst_sched
  import prbs_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8,
  parameter int OWN_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [2*NUM_REQ-1:0]     req_mode,
  input  logic [9*NUM_REQ-1:0]     req_seed,
  input  logic [LEN_W*NUM_REQ-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [OWN_W-1:0]         out_owner,
  output logic                     out_last,
  output logic                     done,
  output logic                     aborted
);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [OWN_W-1:0]     owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [1:0]           mode_q, mode_d;
  logic [LEN_W-1:0]     len_q, len_d, count_q, count_d;
  logic                 valid_q, valid_d, last_q, last_d;
  logic                 done_q, done_d, aborted_q, aborted_d, busy_q, busy_d;
  logic                 lfsr_load, lfsr_step, hs;
  logic [8:0]           lfsr_state;

  logic [1:0]           mode_a [NUM_REQ];
  logic [8:0]           seed_a [NUM_REQ];
  logic [LEN_W-1:0]     len_a  [NUM_REQ];
  logic [OWN_W-1:0]     pick_idx;
  logic                 pick_found;

  function automatic logic [OWN_W-1:0] rr_idx(input logic [OWN_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return OWN_W'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      mode_a[i] = req_mode[2*i +: 2];
      seed_a[i] = req_seed[9*i +: 9];
      len_a[i]  = req_len[LEN_W*i +: LEN_W];
    end
  end

  // Walk from the farthest offset down so the nearest set bit to rr_ptr wins.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[rr_idx(rr_ptr_q, i)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx(rr_ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    mode_d    = mode_q;
    len_d     = len_q;
    count_d   = count_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    hs        = valid_q && out_ready;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_LOAD;
          grant_d = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          mode_d  = mode_a[pick_idx];
          len_d   = len_a[pick_idx];
        end
      end
      ST_LOAD: begin
        lfsr_load = 1'b1;
        count_d   = len_q;
        if (len_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
          valid_d = 1'b1;
          last_d  = (len_q == LEN_W'(1));
        end
      end
      ST_RUN: begin
        if (hs) begin
          lfsr_step = 1'b1;
          count_d   = count_q - LEN_W'(1);
          last_d    = (count_q == LEN_W'(2));
        end
        // A beat accepted together with a req drop still counts; only the
        // final beat turns the drop into a clean completion.
        if (hs && count_q == LEN_W'(1)) begin
          state_d = ST_DONE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!req[owner_q]) begin
          state_d   = ST_DONE;
          valid_d   = 1'b0;
          last_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        rr_ptr_d = rr_idx(owner_q, 1);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      mode_q    <= '0;
      len_q     <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
    end
  end

  prbs_lfsr9 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (seed_a[owner_q]),
    .mode  (mode_q),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_data  = {23'b0, lfsr_state};
  assign out_owner = owner_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule
